// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, boot address and PC step.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDrop = 2'd2
    } fetch_state_e;

    localparam logic [31:0] BootAddressDefault = 32'h0000_1000;
    localparam int unsigned PcIncrement        = 4;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue holding {pc, instruction} pairs between fetch and decode.
module fetch_queue #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [Width-1:0]           push_pc_i,
    input  logic [Width-1:0]           push_instr_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [Width-1:0]           head_pc_o,
    output logic [Width-1:0]           head_instr_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [Width-1:0] pc_q    [Depth];
    logic [Width-1:0] instr_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == DepthCnt);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    assign head_pc_o    = pc_q[rptr_q];
    assign head_instr_o = instr_q[rptr_q];

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                pc_q[wptr_q]    <= push_pc_i;
                instr_q[wptr_q] <= push_instr_i;
                wptr_q          <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory request FSM feeding a small decode queue.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned                ADDRESS_SIZE = 32,
    parameter logic [ADDRESS_SIZE-1:0]    BOOT_ADDRESS = ADDRESS_SIZE'(BootAddressDefault),
    parameter int unsigned                DEPTH        = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    output logic                    mem_req_o,
    output logic [ADDRESS_SIZE-1:0] mem_addr_o,
    input  logic                    mem_ack_i,
    input  logic [ADDRESS_SIZE-1:0] mem_rdata_i,
    input  logic                    redirect_i,
    input  logic [ADDRESS_SIZE-1:0] redirect_pc_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [ADDRESS_SIZE-1:0] out_instruction_o,
    output logic [ADDRESS_SIZE-1:0] out_pc_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
    localparam logic [ADDRESS_SIZE-1:0] PcStep = ADDRESS_SIZE'(PcIncrement);

    fetch_state_e            state_q;
    logic [ADDRESS_SIZE-1:0] fetch_pc_q, mem_addr_q;
    logic                    mem_req_q;

    logic                    q_push, q_pop, q_full, q_empty;
    logic [CntW-1:0]         q_count, count_after;
    logic [ADDRESS_SIZE-1:0] redirect_target, next_pc;
    logic                    unused_pc_lsb;

    assign redirect_target = {redirect_pc_i[ADDRESS_SIZE-1:2], 2'b00};
    assign unused_pc_lsb   = ^redirect_pc_i[1:0];
    assign next_pc         = mem_addr_q + PcStep;

    assign q_push      = (state_q == StWait) && mem_ack_i && !redirect_i;
    assign out_valid_o = !q_empty && !redirect_i;
    assign q_pop       = out_valid_o && out_ready_i;
    // Occupancy after this cycle's push, accounting for a simultaneous pop.
    assign count_after = q_count + CntW'(1) - CntW'(q_pop);

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            fetch_pc_q <= BOOT_ADDRESS;
            mem_addr_q <= BOOT_ADDRESS;
            mem_req_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (redirect_i) begin
                        fetch_pc_q <= redirect_target;
                    end else if (!q_full) begin
                        state_q    <= StWait;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc_q;
                    end
                end
                StWait: begin
                    if (redirect_i) begin
                        fetch_pc_q <= redirect_target;
                        if (mem_ack_i) begin
                            state_q   <= StIdle;
                            mem_req_q <= 1'b0;
                        end else begin
                            state_q <= StDrop;
                        end
                    end else if (mem_ack_i) begin
                        fetch_pc_q <= next_pc;
                        mem_addr_q <= next_pc;
                        if (count_after >= DepthCnt) begin
                            state_q   <= StIdle;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                StDrop: begin
                    // The stale response is swallowed; mem_addr stays on the old request.
                    if (redirect_i) begin
                        fetch_pc_q <= redirect_target;
                    end
                    if (mem_ack_i) begin
                        state_q   <= StIdle;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    fetch_queue #(
        .Width (ADDRESS_SIZE),
        .Depth (DEPTH)
    ) u_queue (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (q_push),
        .push_pc_i    (mem_addr_q),
        .push_instr_i (mem_rdata_i),
        .pop_i        (q_pop),
        .flush_i      (redirect_i),
        .head_pc_o    (out_pc_o),
        .head_instr_o (out_instruction_o),
        .count_o      (q_count),
        .full_o       (q_full),
        .empty_o      (q_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic against a queue model.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BOOT  = 32'h0000_1000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_instruction_o;
    logic [31:0] out_pc_o;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: fetched entries awaiting decode, plus the outstanding request.
    logic [31:0] m_pc[$];
    logic [31:0] m_ins[$];
    logic [31:0] popped[$];
    bit          m_out;
    bit          m_stale;
    logic [31:0] m_next;
    logic [31:0] m_req;

    always #5 clk_i = ~clk_i;

    fetch_unit #(
        .ADDRESS_SIZE (32),
        .BOOT_ADDRESS (BOOT),
        .DEPTH        (DEPTH)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .mem_req_o         (mem_req_o),
        .mem_addr_o        (mem_addr_o),
        .mem_ack_i         (mem_ack_i),
        .mem_rdata_i       (mem_rdata_i),
        .redirect_i        (redirect_i),
        .redirect_pc_i     (redirect_pc_i),
        .out_valid_o       (out_valid_o),
        .out_ready_i       (out_ready_i),
        .out_instruction_o (out_instruction_o),
        .out_pc_o          (out_pc_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc.delete();
        m_ins.delete();
        m_out   = 1'b0;
        m_stale = 1'b0;
        m_next  = BOOT;
        m_req   = BOOT;
    endtask

    task automatic model_step();
        int n0;
        bit pop;
        n0  = m_pc.size();
        pop = (n0 != 0) && !redirect_i && out_ready_i;
        if (redirect_i) begin
            m_pc.delete();
            m_ins.delete();
            m_next = {redirect_pc_i[31:2], 2'b00};
            if (m_out) begin
                if (mem_ack_i) begin
                    m_out   = 1'b0;
                    m_stale = 1'b0;
                end else begin
                    m_stale = 1'b1;
                end
            end
        end else begin
            if (pop) begin
                popped.push_back(m_pc.pop_front());
                void'(m_ins.pop_front());
            end
            if (m_out && mem_ack_i) begin
                if (m_stale) begin
                    m_out   = 1'b0;
                    m_stale = 1'b0;
                end else begin
                    m_pc.push_back(m_req);
                    m_ins.push_back(mem_rdata_i);
                    m_next = m_req + 32'd4;
                    m_req  = m_next;
                    if (m_pc.size() >= int'(DEPTH)) m_out = 1'b0;
                end
            end else if (!m_out && n0 < int'(DEPTH)) begin
                m_out = 1'b1;
                m_req = m_next;
            end
        end
    endtask

    task automatic check_outputs();
        bit exp_valid;
        exp_valid = (m_pc.size() != 0) && !redirect_i;
        chk("mem_req", 32'(mem_req_o), 32'(m_out));
        if (m_out) chk("mem_addr", mem_addr_o, m_req);
        chk("out_valid", 32'(out_valid_o), 32'(exp_valid));
        if (exp_valid) begin
            chk("out_pc", out_pc_o, m_pc[0]);
            chk("out_instr", out_instruction_o, m_ins[0]);
        end
        chk("push_when_full", 32'(dut.q_push & dut.q_full), 32'd0);
    endtask

    // One clock: drive inputs on the falling edge, check, then advance the model on the rising edge.
    task automatic cycle(input bit r, input logic [31:0] rpc, input bit rdy, input int ack_pct,
                         input bit spur);
        @(negedge clk_i);
        redirect_i    = r;
        redirect_pc_i = rpc;
        out_ready_i   = rdy;
        mem_ack_i     = m_out ? (int'($urandom_range(99)) < ack_pct) : spur;
        mem_rdata_i   = $urandom();
        #1 check_outputs();
        @(posedge clk_i) model_step();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni      = 1'b0;
        redirect_i  = 1'b0;
        mem_ack_i   = 1'b0;
        out_ready_i = 1'b0;
        model_reset();
        @(posedge clk_i);
        #2 rst_ni = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, BOOT);
        chk("rst_out_pc", out_pc_o, 32'd0);
        chk("rst_out_instr", out_instruction_o, 32'd0);
        @(posedge clk_i);
        #2 rst_ni = 1'b1;

        // Zero-wait streaming from boot address.
        popped.delete();
        repeat (8) cycle(1'b0, 32'd0, 1'b1, 100, 1'b0);
        chk("stream_count", popped.size(), 32'd6);
        if (popped.size() >= 3) begin
            chk("stream_pc0", popped[0], 32'h1000);
            chk("stream_pc1", popped[1], 32'h1004);
            chk("stream_pc2", popped[2], 32'h1008);
        end

        // Back-pressure fills the queue, then one pop restarts fetch.
        do_reset();
        repeat (7) cycle(1'b0, 32'd0, 1'b0, 100, 1'b0);
        #1;
        chk("full_mem_req", 32'(mem_req_o), 32'd0);
        chk("full_count", 32'(dut.q_count), 32'd4);
        cycle(1'b0, 32'd0, 1'b1, 100, 1'b0);
        cycle(1'b0, 32'd0, 1'b0, 100, 1'b0);
        #1;
        chk("refill_req", 32'(mem_req_o), 32'd1);
        chk("refill_addr", mem_addr_o, 32'h1010);

        // Redirect while waiting on a slow response.
        do_reset();
        cycle(1'b0, 32'd0, 1'b1, 0, 1'b0);
        cycle(1'b0, 32'd0, 1'b1, 0, 1'b0);
        cycle(1'b1, 32'h2000, 1'b1, 0, 1'b0);
        cycle(1'b0, 32'd0, 1'b1, 0, 1'b0);
        cycle(1'b0, 32'd0, 1'b1, 100, 1'b0);
        cycle(1'b0, 32'd0, 1'b1, 0, 1'b0);
        #1;
        chk("redir_req", 32'(mem_req_o), 32'd1);
        chk("redir_addr", mem_addr_o, 32'h2000);
        popped.delete();
        repeat (4) cycle(1'b0, 32'd0, 1'b1, 100, 1'b0);
        chk("redir_first_pc", (popped.size() > 0) ? popped[0] : 32'hDEAD_BEEF, 32'h2000);

        // Redirect coinciding with the ack, misaligned target.
        cycle(1'b1, 32'h3002, 1'b1, 100, 1'b0);
        cycle(1'b0, 32'd0, 1'b1, 0, 1'b0);
        #1;
        chk("same_cyc_req", 32'(mem_req_o), 32'd1);
        chk("same_cyc_addr", mem_addr_o, 32'h3000);

        // PC wraps at the top of the address space.
        cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 100, 1'b0);
        popped.delete();
        repeat (6) cycle(1'b0, 32'd0, 1'b1, 100, 1'b0);
        chk("wrap_count", 32'(popped.size() >= 3), 32'd1);
        if (popped.size() >= 3) begin
            chk("wrap_pc0", popped[0], 32'hFFFF_FFF8);
            chk("wrap_pc1", popped[1], 32'hFFFF_FFFC);
            chk("wrap_pc2", popped[2], 32'h0000_0000);
        end

        // Asynchronous reset with a request in flight and two queued entries.
        do_reset();
        repeat (3) cycle(1'b0, 32'd0, 1'b0, 100, 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_mem_req", 32'(mem_req_o), 32'd0);
        chk("async_out_valid", 32'(out_valid_o), 32'd0);
        chk("async_mem_addr", mem_addr_o, BOOT);
        model_reset();
        @(posedge clk_i);
        #2 rst_ni = 1'b1;
        cycle(1'b0, 32'd0, 1'b1, 0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(19) == 0, $urandom(), $urandom_range(3) != 0, 50,
                  $urandom_range(7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDRESS_SIZE, default 32, address/instruction width.
REQ-002 Parameter BOOT_ADDRESS, default 32'h1000, first fetch PC after reset.
REQ-003 Parameter DEPTH, default 4, instruction-queue entries (power of two).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 mem_req  output  1  fetch request to instruction memory, held until mem_ack.
REQ-007 mem_addr  output  ADDRESS_SIZE  word-aligned fetch address, stable while mem_req=1.
REQ-008 mem_ack  input  1  one-cycle pulse: mem_rdata valid for the outstanding request.
REQ-009 mem_rdata  input  ADDRESS_SIZE  fetched instruction.
REQ-010 redirect  input  1  one-cycle request to restart fetch at redirect_pc.
REQ-011 redirect_pc  input  ADDRESS_SIZE  new fetch PC, bits [1:0] forced to 0.
REQ-012 out_valid  output  1  queue head valid toward decode.
REQ-013 out_ready  input  1  decode accepts head this cycle.
REQ-014 out_instruction  output  ADDRESS_SIZE  instruction at queue head.
REQ-015 out_pc  output  ADDRESS_SIZE  PC of queue head.

Function
REQ-016 At most one memory request outstanding; mem_req = 1 exactly in states WAIT and DROP.
REQ-017 States: IDLE (no request), WAIT (request for fetch_pc outstanding), DROP (stale request outstanding, response discarded).
REQ-018 IDLE -> WAIT when queue count < DEPTH and redirect=0; mem_addr latched = fetch_pc.
REQ-019 WAIT, mem_ack=1, redirect=0: push {mem_addr, mem_rdata}; fetch_pc and mem_addr += 4; stay WAIT if post-push count < DEPTH (counting same-cycle pop), else IDLE.
REQ-020 WAIT, redirect=1, mem_ack=0: flush queue, fetch_pc = redirect_pc, -> DROP.
REQ-021 WAIT, redirect=1, mem_ack=1: discard mem_rdata, flush queue, fetch_pc = redirect_pc, -> IDLE.
REQ-022 DROP: mem_addr held; on mem_ack discard data -> IDLE; redirect in DROP updates fetch_pc, stays DROP (or -> IDLE if mem_ack same cycle).
REQ-023 IDLE, redirect=1: flush, fetch_pc = redirect_pc, stay IDLE that cycle.
REQ-024 mem_ack in IDLE ignored.
REQ-025 PC arithmetic modulo 2^ADDRESS_SIZE: 32'hFFFFFFFC + 4 -> 32'h0.
REQ-026 Queue: circular FIFO, read/write pointers wrap modulo DEPTH, count 0..DEPTH; out_valid = (count != 0) and redirect=0.
REQ-027 Pop when out_valid and out_ready; simultaneous push and pop leaves count unchanged.
REQ-028 Flush (redirect) dominates push and pop in the same cycle: count=0, pointers=0.
REQ-029 Push never occurs with count=DEPTH (guaranteed by REQ-018/019); verification asserts this.
REQ-030 Latency: zero-wait memory (mem_ack same cycle as mem_req) -> first out_valid 2 cycles after first edge with reset high; sustained 1 instruction/cycle with out_ready=1.

Reset
REQ-031 reset=0 asynchronously forces: state IDLE, fetch_pc = mem_addr = BOOT_ADDRESS, count and pointers 0, queue storage 0, mem_req=0, out_valid=0, out_instruction=0, out_pc=0.
REQ-032 Reset mid-request abandons the outstanding request; a mem_ack arriving after release in IDLE is ignored.

Structure
REQ-033 Shared package holds state encoding (IDLE/WAIT/DROP), BOOT_ADDRESS default, and PC increment constant 4.
REQ-034 Queue implemented as sub-module fetch_queue (push, pop, flush, count, full/empty); FSM and PC logic in fetch_unit.

Verification
REQ-035 Reset release, zero-wait memory, out_ready=1 -> mem_addr 0x1000,0x1004,0x1008 on consecutive cycles; out_pc same order, 1/cycle.
REQ-036 out_ready=0, zero-wait memory -> exactly 4 pushes, mem_req=0 and state IDLE; out_ready=1 one cycle -> one pop, one new request at 0x1010.
REQ-037 mem_ack delayed 3 cycles, redirect to 0x2000 at cycle 1 of wait -> queue empty, that ack's data never appears; next mem_addr 0x2000.
REQ-038 redirect and mem_ack same cycle, redirect_pc 0x3002 -> data dropped, next request 0x3000, out_valid=0 that cycle.
REQ-039 redirect_pc 0xFFFFFFF8, zero-wait -> out_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-040 reset=0 asserted while WAIT with 2 queued entries -> next sample: mem_req=0, out_valid=0, mem_addr 0x1000.
